shift_add_pipe: RTL and testbench

- Runtime-programmable, multi-lane, pipelined signed multiplier built on shift-add terms.
- A weight is loaded at run time. An internal FSM decomposes it, one term per cycle, into up to DEPTH signed power-of-two terms.
- Data then streams through LANES parallel lanes under valid/ready flow control.
- If the weight cannot be represented exactly in DEPTH terms, the block falls back to a full multiply. It replaces fixed-weight shift-add instances in the 2D conv datapath wherever the weight changes between layers.

---
 rtl/shift_add_pipe.sv | 146 ++++++++++++++
 tb/tb_shift_add_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_pipe.sv
// shift_add_pipe: multi-lane pipelined signed multiplier using a run-time weight split into
// up to DEPTH signed power-of-two terms, with a full-multiply fallback for inexact weights.
module shift_add_pipe #(
  parameter int DATA_W = 16,
  parameter int WGT_W  = 16,
  parameter int DEPTH  = 2,
  parameter int LANES  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wgt_load,
  input  logic [WGT_W-1:0]                 wgt_in,
  output logic                             wgt_busy,
  output logic                             wgt_exact,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*DATA_W-1:0]          data_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*(DATA_W+WGT_W)-1:0]  data_out
);
  localparam int PW = DATA_W + WGT_W;
  localparam int EW = $clog2(WGT_W);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {READY, DRAIN, DECOMP} state_t;

  state_t                  r_state, w_next;
  logic signed [WGT_W-1:0] r_weight;
  logic signed [WGT_W:0]   r_res;
  logic [EW-1:0]           r_exp [DEPTH];
  logic [DEPTH-1:0]        r_neg, r_tv;
  logic [IW-1:0]           r_cnt;
  logic                    r_exact, r_s1_v, r_out_v;
  logic signed [PW-1:0]    r_s1 [LANES][DEPTH];
  logic [LANES*PW-1:0]     r_out;

  logic [WGT_W:0]          w_mag;
  logic [WGT_W+1:0]        w_pow, w_diff, w_best;
  logic [EW-1:0]           w_e;
  logic signed [WGT_W:0]   w_term, w_res_nx;
  logic                    w_done, w_adv, w_acc;
  logic signed [PW-1:0]    w_wx;
  logic signed [PW-1:0]    w_x   [LANES];
  logic signed [PW-1:0]    w_s1  [LANES][DEPTH];
  logic signed [PW-1:0]    w_sum [LANES];

  // Nearest power of two to |residue|; '<=' lets a tie resolve to the larger exponent.
  always_comb begin
    w_mag  = r_res[WGT_W] ? $unsigned(-r_res) : $unsigned(r_res);
    w_best = '1;
    w_e    = '0;
    w_pow  = '0;
    w_diff = '0;
    for (int i = 0; i < WGT_W; i++) begin
      w_pow  = (WGT_W+2)'(1) << i;
      w_diff = ({1'b0, w_mag} >= w_pow) ? {1'b0, w_mag} - w_pow : w_pow - {1'b0, w_mag};
      if (w_diff <= w_best) begin
        w_best = w_diff;
        w_e    = EW'(i);
      end
    end
    w_term   = $signed((WGT_W+1)'(1) << w_e);
    w_res_nx = r_res[WGT_W] ? r_res + w_term : r_res - w_term;
  end

  always_comb begin
    w_done = r_res == '0 || w_res_nx == '0 || r_cnt == IW'(DEPTH-1);
    w_next = (r_state == READY && wgt_load)            ? DRAIN  :
             (r_state == DRAIN && !r_s1_v && !r_out_v) ? DECOMP :
             (r_state == DECOMP && w_done)             ? READY  : r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= READY;
      r_weight <= '0;
      r_res    <= '0;
      r_exp    <= '{default: '0};
      r_neg    <= '0;
      r_tv     <= '0;
      r_cnt    <= '0;
      r_exact  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == READY && wgt_load) begin
        r_weight <= wgt_in;
        r_res    <= {wgt_in[WGT_W-1], wgt_in};
        r_exp    <= '{default: '0};
        r_neg    <= '0;
        r_tv     <= '0;
        r_cnt    <= '0;
      end else if (r_state == DECOMP && r_res != '0) begin
        r_exp[r_cnt] <= w_e;
        r_neg[r_cnt] <= r_res[WGT_W];
        r_tv[r_cnt]  <= 1'b1;
        r_res        <= w_res_nx;
        r_cnt        <= r_cnt + 1'b1;
      end
      if (r_state == DECOMP && w_done)
        r_exact <= r_res == '0 || w_res_nx == '0;
    end
  end

  assign wgt_busy  = r_state != READY;
  assign wgt_exact = r_exact;
  assign w_adv     = !r_out_v || out_ready;
  assign in_ready  = w_adv && r_state == READY && !wgt_load;
  assign w_acc     = in_valid && in_ready;

  // Fallback multiply lands in term slot 0 so stage 2 sums identically either way.
  always_comb begin
    w_wx = PW'(r_weight);
    for (int l = 0; l < LANES; l++) begin
      w_x[l]   = PW'($signed(data_in[l*DATA_W +: DATA_W]));
      w_sum[l] = '0;
      for (int d = 0; d < DEPTH; d++) begin
        w_s1[l][d] = !r_exact ? (d == 0 ? w_x[l] * w_wx : '0) :
                     !r_tv[d] ? '0 :
                     r_neg[d] ? -(w_x[l] <<< r_exp[d]) : (w_x[l] <<< r_exp[d]);
        w_sum[l]   = w_sum[l] + r_s1[l][d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v  <= 1'b0;
      r_out_v <= 1'b0;
      r_s1    <= '{default: '0};
      r_out   <= '0;
    end else if (w_adv) begin
      r_s1_v  <= w_acc;
      r_out_v <= r_s1_v;
      if (w_acc)
        r_s1 <= w_s1;
      if (r_s1_v)
        for (int l = 0; l < LANES; l++)
          r_out[l*PW +: PW] <= w_sum[l];
    end
  end

  assign out_valid = r_out_v;
  assign data_out  = r_out;

endmodule

// File: tb/tb_shift_add_pipe.sv
// tb_shift_add_pipe: directed vectors for shift_add_pipe with hand-computed products.
module tb_shift_add_pipe;
  localparam int DW = 16, WW = 16, L = 4, PW = DW + WW;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              wgt_load = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [WW-1:0]     wgt_in = '0;
  logic [L*DW-1:0]   data_in = '0;
  logic              wgt_busy, wgt_exact, in_ready, out_valid;
  logic [L*PW-1:0]   data_out;

  int n_vec = 0, n_err = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  shift_add_pipe #(.DATA_W(DW), .WGT_W(WW), .DEPTH(2), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .wgt_load(wgt_load), .wgt_in(wgt_in),
    .wgt_busy(wgt_busy), .wgt_exact(wgt_exact), .in_valid(in_valid),
    .in_ready(in_ready), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lane(input int l);
    return longint'($signed(data_out[l*PW +: PW]));
  endfunction

  function automatic logic [L*DW-1:0] pack(input logic signed [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic int sval(input int k, input int l);
    return k * 1000 + l * 37 - 3000;
  endfunction

  task automatic load_w(input logic signed [WW-1:0] w, input bit with_beat,
                        input int exp_busy, input bit exp_exact);
    int cnt;
    bit seen;
    @(negedge clk);
    wgt_load = 1'b1; wgt_in = w; in_valid = with_beat; data_in = {4{16'sd9}};
    #1 chk("load_in_ready", in_ready, 0);
    @(negedge clk);
    wgt_load = 1'b0; in_valid = 1'b0;
    cnt = 0; seen = 1'b0;
    while (wgt_busy && cnt < 50) begin
      cnt++;
      seen |= out_valid;
      @(negedge clk);
    end
    chk("busy_cycles", cnt, exp_busy);
    chk("exact", wgt_exact, exp_exact);
    chk("no_spurious_out", seen | out_valid, 0);
  endtask

  task automatic beat(input logic signed [DW-1:0] a, b, c, d,
                      input longint e0, e1, e2, e3);
    @(negedge clk);
    data_in = pack(a, b, c, d); in_valid = 1'b1;
    #1 chk("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat1_ov", out_valid, 0);
    @(negedge clk);
    chk("lat2_ov", out_valid, 1);
    chk("lane0", lane(0), e0);
    chk("lane1", lane(1), e1);
    chk("lane2", lane(2), e2);
    chk("lane3", lane(3), e3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv, cyc, cnt;
    bit stalled;
    longint h0, h3;
    #12;
    chk("rst_ov", out_valid, 0);
    chk("rst_dout0", lane(0), 0);
    chk("rst_dout3", lane(3), 0);
    chk("rst_busy", wgt_busy, 0);
    chk("rst_exact", wgt_exact, 1);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("idle_in_ready", in_ready, 1);

    load_w(16'sd3, 1'b0, 3, 1'b1);
    beat(5, -2, 0, 100, 15, -6, 0, 300);

    load_w(16'sd11, 1'b0, 3, 1'b0);
    beat(-7, 32767, 0, 1, -77, 360437, 0, 11);

    load_w(16'sd0, 1'b1, 2, 1'b1);
    beat(1234, -5, 7, -32768, 0, 0, 0, 0);

    load_w(-16'sd32768, 1'b0, 2, 1'b1);
    beat(2, -1, 32767, -32768, -65536, 32768, -1073709056, 1073741824);

    load_w(-16'sd3, 1'b0, 3, 1'b1);
    sent = 0; rcv = 0; cyc = 0; stalled = 1'b0; h0 = 0; h3 = 0;
    while (rcv < 8 && cyc < 200) begin
      @(negedge clk);
      if (stalled) begin
        chk("stall_hold0", lane(0), h0);
        chk("stall_hold3", lane(3), h3);
      end
      out_ready = pat[cyc % 4];
      cyc++;
      in_valid = sent < 8;
      for (int l = 0; l < L; l++) data_in[l*DW +: DW] = DW'(sval(sent, l));
      #1;
      stalled = out_valid && !out_ready;
      if (stalled) begin
        h0 = lane(0); h3 = lane(3);
        chk("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        for (int l = 0; l < L; l++) chk("stream_lane", lane(l), -3 * sval(rcv, l));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_rcv", rcv, 8);

    @(negedge clk);
    out_ready = 1'b0;
    data_in = pack(11, -4, 0, 1); in_valid = 1'b1;
    #1 chk("drain_acc1", in_ready, 1);
    @(negedge clk);
    data_in = pack(-6, 2, 3, 5);
    #1 chk("drain_acc2", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; wgt_load = 1'b1; wgt_in = 16'sd7;
    @(negedge clk);
    wgt_load = 1'b0;
    chk("drain_busy", wgt_busy, 1);
    repeat (3) @(negedge clk);
    chk("drain_hold_busy", wgt_busy, 1);
    chk("drain_a0", lane(0), -33);
    chk("drain_a3", lane(3), -3);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_b_ov", out_valid, 1);
    chk("drain_b0", lane(0), 18);
    chk("drain_b3", lane(3), -15);
    cnt = 0;
    while (wgt_busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("drain_busy_cycles", cnt, 4);
    chk("drain_exact", wgt_exact, 1);
    beat(3, -1, 0, 0, 21, -7, 0, 0);

    @(negedge clk);
    wgt_load = 1'b1; wgt_in = 16'sd11;
    @(negedge clk);
    wgt_load = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", wgt_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", wgt_busy, 0);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_exact", wgt_exact, 1);
    @(negedge clk) rst_n = 1'b1;
    beat(100, -100, 1, 2, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
